fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Program-sequencing unit for the 9-bit single-cycle core. Owns the program counter (ProgCtr), the start/ack run handshake, the architectural FLAG and OVERFLOW status bits, and absolute branch-target lookup.
- Consumes the control decoder outputs (branch_en, flag_write, overflow_write) plus ALU results.
- Drives ProgCtr to the combinational instruction ROM.

Parameters:
- PC_W, 10, program counter width; ROM depth is 2^PC_W.
- LUT_IDX_W, 3, width of the branch-target table index.
- START_PC, 0, PC value loaded on each Start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level request: held high = load/hold, falling edge = begin run.
- branch_en  input  1  taken-branch request from the decoder.
- branch_idx  input  LUT_IDX_W  branch-target table index (instruction bits [5:3]).
- halt  input  1  current instruction is HALT.
- flag_write  input  1  update FLAG this cycle.
- flag_in  input  1  ALU compare result.
- overflow_write  input  1  update OVERFLOW this cycle.
- overflow_in  input  1  ALU carry/overflow result.
- ProgCtr  output  PC_W  current instruction address, registered.
- flag_q  output  1  architectural FLAG, fed back to the decoder FLAG_IN.
- overflow_q  output  1  architectural OVERFLOW bit.
- running  output  1  high while in RUN.
- Ack  output  1  program done, registered.

Behaviour:
- Reset values: ProgCtr=START_PC, flag_q=0, overflow_q=0, running=0, Ack=0, state=IDLE.
- States: IDLE, LOAD, RUN, DONE. Transitions:
  - IDLE: Start=1 -> LOAD.
  - LOAD: ProgCtr<=START_PC, flag_q<=0, overflow_q<=0, Ack<=0. Stay while Start=1; Start=0 -> RUN.
  - RUN: running=1; one instruction per cycle. Priority is Start > halt > branch_en > increment.
    - Start=1 -> LOAD (abort; PC not advanced).
    - halt=1 -> DONE; PC holds.
    - branch_en=1 -> ProgCtr<=target_lut[branch_idx].
    - Otherwise ProgCtr<=ProgCtr+1.
  - DONE: Ack=1, running=0, PC holds. Start=1 -> LOAD, which clears Ack.
- Runoff: in RUN with ProgCtr = 2^PC_W-1 and no branch/halt -> DONE with Ack=1. PC never wraps.
- Status writes occur only in RUN and only when Start=0.
  - flag_q<=flag_in when flag_write; overflow_q<=overflow_in when overflow_write.
  - Both may update in the same cycle.
  - Writes are still committed in the cycle halt=1 (the HALT instruction itself does not write, so this is benign).
- Branch latency: the decoder sees the current flag_q combinationally. A taken branch is visible on ProgCtr the next cycle; there are no delay slots. A flag written in cycle N affects branch decisions from cycle N+1.
- Reset mid-run overrides everything on the next edge. All ports return to reset values; any in-progress status write is discarded.
- All inputs except Start and Reset are ignored in IDLE, LOAD and DONE.
- target_lut: constant table of 2^LUT_IDX_W PC_W-bit entries, defined in the package. Branch targets are absolute.

Optional Feature:
- Macro INSTR_COUNT_EN.
- When defined:
  - Adds output instr_ct [15:0].
  - Cleared in LOAD and on Reset.
  - Increments by 1 every RUN cycle that does not exit to LOAD, including the halt cycle.
  - Saturates at 16'hFFFF.
  - Holds in DONE.
- When undefined: port and logic are absent; there is no other behavioural difference.

Decomposition:
- Package definitions gains:
  - typedef enum logic[1:0] {IDLE, LOAD, RUN, DONE} seq_state_t.
  - localparam START_PC_DEFAULT.
  - The target_lut constant array.
- One sub-module: branch_lut. It is combinational, maps branch_idx to target, and is instantiated once.

Test Plan:
- Reset held 2 cycles, then Start high 3 cycles, then low -> ProgCtr=0 through LOAD; then 0,1,2,3 in successive cycles; running=1, Ack=0.
- Branch: target_lut[2]=10'h040, branch_idx=2, branch_en=1 at PC=5 -> next ProgCtr=0x040, then 0x041.
- Flag: flag_write=1, flag_in=1 at PC=3 -> flag_q=1 from cycle 4. flag_write=0 with flag_in=0 at PC=4 -> flag_q stays 1.
- Conflicts: halt=1 with branch_en=1 at PC=7 -> DONE, ProgCtr=7, Ack=1. Start=1 later -> Ack=0, ProgCtr=0, flag_q=0.
- Runoff: PC_W=4, no branches -> after PC=15, Ack=1 and ProgCtr stays 15. Reset asserted at PC=9 in RUN -> next cycle all outputs at reset values.
- INSTR_COUNT_EN: 6-instruction program ending in HALT -> instr_ct=6 in DONE; cleared on restart.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state type, default start PC and absolute branch-target table
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  localparam int START_PC_DEFAULT = 0;
  localparam int LUT_PC_W         = 10;
  localparam int LUT_DEPTH        = 8;

  // Absolute branch targets; narrower PC builds keep the low bits.
  localparam logic [LUT_PC_W-1:0] target_lut [LUT_DEPTH] = '{
    10'h000, 10'h012, 10'h040, 10'h07F,
    10'h100, 10'h1A5, 10'h2C0, 10'h3FE
  };

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// rtl/fetch_sequencer_branch_lut.sv - combinational branch index to absolute target lookup
module branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3
) (
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      target
);

  logic [LUT_PC_W-1:0] raw;

  always_comb begin
    raw = target_lut[branch_idx];
  end

  assign target = PC_W'(raw);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, start/ack run control and FLAG/OVERFLOW status
// Optional INSTR_COUNT_EN adds a saturating retired-instruction counter output instr_ct.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3,
  parameter int START_PC  = START_PC_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 halt,
  input  logic                 flag_write,
  input  logic                 flag_in,
  input  logic                 overflow_write,
  input  logic                 overflow_in,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 flag_q,
  output logic                 overflow_q,
  output logic                 running,
  output logic                 Ack
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]          instr_ct
`endif
);

  localparam logic [PC_W-1:0] PC_START = PC_W'(START_PC);
  localparam logic [PC_W-1:0] PC_LAST  = '1;
  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

  seq_state_t      state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] target;
  logic            flag_n;
  logic            ovf_n;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .branch_idx (branch_idx),
    .target     (target)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= PC_START;
      flag_q     <= 1'b0;
      overflow_q <= 1'b0;
      Ack        <= 1'b0;
    end else begin
      state      <= state_n;
      ProgCtr    <= pc_n;
      flag_q     <= flag_n;
      overflow_q <= ovf_n;
      Ack        <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = ProgCtr;
    flag_n  = flag_q;
    ovf_n   = overflow_q;
    unique case (state)
      IDLE: begin
        if (Start) state_n = LOAD;
      end
      LOAD: begin
        pc_n   = PC_START;
        flag_n = 1'b0;
        ovf_n  = 1'b0;
        if (!Start) state_n = RUN;
      end
      RUN: begin
        if (Start) begin
          state_n = LOAD;
        end else begin
          if (flag_write)     flag_n = flag_in;
          if (overflow_write) ovf_n  = overflow_in;
          if (halt) begin
            state_n = DONE;
          end else if (branch_en) begin
            pc_n = target;
          end else if (ProgCtr == PC_LAST) begin
            // Falling off the end of ROM finishes the program instead of wrapping.
            state_n = DONE;
          end else begin
            pc_n = ProgCtr + PC_ONE;
          end
        end
      end
      DONE: begin
        if (Start) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  assign running = (state == RUN);

`ifdef INSTR_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset || state == LOAD) begin
      instr_ct <= 16'h0000;
    end else if (state == RUN && !Start && instr_ct != 16'hFFFF) begin
      instr_ct <= instr_ct + 16'd1;
    end
  end
`endif

endmodule
